// File: rtl/vga_pkg.sv
// Shared types, constants and the nibble-to-ASCII helper for the VGA hex writer.
// Optional macro VGA_HEX_PREFIX_EN adds a "0x" prefix to every burst (NCHAR=10).
package vga_pkg;

  localparam int unsigned CHAR_ADDR_W = 12;
  localparam logic [7:0]  ASCII_0     = 8'h30;
  localparam logic [7:0]  ASCII_A     = 8'h41;
  localparam logic [7:0]  ASCII_X     = 8'h78;

`ifdef VGA_HEX_PREFIX_EN
  localparam int unsigned NCHAR = 10;
`else
  localparam int unsigned NCHAR = 8;
`endif

  typedef enum logic {IDLE, EMIT} state_e;

  typedef struct packed {
    logic [CHAR_ADDR_W-1:0] addr;
    logic [31:0]            value;
  } req_t;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'h0, nib};
    else             return ASCII_A + {4'h0, nib - 4'd10};
  endfunction

endpackage

// File: rtl/vga_req_fifo.sv
// Synchronous request FIFO with asynchronous active-high reset.
// Full/empty depend only on the occupancy count, so a pop never frees a slot for a same-cycle push.
module vga_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 44
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];

  always_comb begin
    wr_d    = do_push ? wr_q + PtrW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + PtrW'(1) : rd_q;
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/vga_hex_writer.sv
// Renders queued 32-bit values as hex text bursts into the VGA character buffer write port.
// Define VGA_HEX_PREFIX_EN to prefix each burst with "0x".
module vga_hex_writer
  import vga_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = CHAR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_value,
  output logic              wen,
  output logic [ADDR_W-1:0] w_addr,
  output logic [7:0]        w_data,
  output logic              busy
);

  localparam int unsigned EntryW  = ADDR_W + 32;
  localparam logic [3:0]  LastCnt = 4'(NCHAR - 1);

  logic              full, empty, pop;
  logic [EntryW-1:0] head;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_value;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       value_q, value_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [7:0]        data_q, data_d;
  logic              shift_en;

  vga_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid),
    .pop_i   (pop),
    .data_i  ({req_addr, req_value}),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign head_addr  = head[EntryW-1:32];
  assign head_value = head[31:0];

`ifdef VGA_HEX_PREFIX_EN
  // Digits start at cnt==2; hold the shifter through the two prefix characters.
  assign shift_en = (cnt_q >= 4'd2);
`else
  assign shift_en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    addr_d  = addr_q;
    wen_d   = 1'b0;
    data_d  = data_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: pop = !empty;
      EMIT: begin
        if (cnt_q == LastCnt) begin
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          addr_d  = addr_q + ADDR_W'(1);
          value_d = shift_en ? {value_q[27:0], 4'h0} : value_q;
          wen_d   = 1'b1;
          data_d  = hex_char(value_d[31:28]);
`ifdef VGA_HEX_PREFIX_EN
          if (cnt_q == 4'd0) data_d = ASCII_X;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading registers the first character so bursts chain with no idle cycle.
    if (pop) begin
      state_d = EMIT;
      cnt_d   = 4'd0;
      value_d = head_value;
      addr_d  = head_addr;
      wen_d   = 1'b1;
`ifdef VGA_HEX_PREFIX_EN
      data_d  = ASCII_0;
`else
      data_d  = hex_char(head_value[31:28]);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      value_q <= 32'h0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      data_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
    end
  end

  assign wen       = wen_q;
  assign w_addr    = addr_q;
  assign w_data    = data_q;
  assign req_ready = !full;
  assign busy      = !empty || (state_q == EMIT);

endmodule

// File: tb/tb_vga_hex_writer.sv
// Scoreboard bench for vga_hex_writer: pushes expected writes per accepted request,
// a negedge monitor pops and compares every display write.
module tb_vga_hex_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [31:0] req_value;
  logic        wen;
  logic [11:0] w_addr;
  logic [7:0]  w_data;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [19:0] exp_q[$];
  int unsigned run_len = 0;
  int unsigned max_run = 0;

  vga_hex_writer #(
    .FIFO_DEPTH (4),
    .ADDR_W     (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_value (req_value),
    .wen       (wen),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  task automatic expect_burst(input logic [11:0] addr, input logic [31:0] val);
    logic [11:0] a;
    a = addr;
`ifdef VGA_HEX_PREFIX_EN
    exp_q.push_back({a, 8'h30}); a = a + 12'd1;
    exp_q.push_back({a, 8'h78}); a = a + 12'd1;
`endif
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({a, model_hex(val[31-4*i -: 4])});
      a = a + 12'd1;
    end
  endtask

  // Presents a request and holds it until accepted; returns #1 after the accepting edge.
  task automatic push(input logic [11:0] addr, input logic [31:0] val);
    req_valid = 1'b1;
    req_addr  = addr;
    req_value = val;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) break;
      @(posedge clk); #1;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: got ready=0 expected ready=1");
    end else begin
      @(posedge clk);
      expect_burst(addr, val);
      #1;
    end
    req_valid = 1'b0;
    req_value = 32'hFFFF_FFFF;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({name, "_busy"}, busy, 0);
    chk({name, "_queue"}, exp_q.size(), 0);
    chk({name, "_wen"}, wen, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (wen) begin
      logic [19:0] e;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", w_addr, w_data);
      end else begin
        e = exp_q.pop_front();
        if ({w_addr, w_data} !== e) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   w_addr, w_data, e[19:8], e[7:0]);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nchars;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_wen", wen, 0);
    chk("rst_waddr", w_addr, 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single burst with latency check.
    push(12'h010, 32'hDEADBEEF);
    @(negedge clk);
    chk("lat_e0_wen", wen, 0);
    chk("lat_e0_busy", busy, 1);
    @(negedge clk);
    chk("lat_e1_wen", wen, 1);
    chk("lat_e1_addr", w_addr, 12'h010);
    wait_idle("single");

    // Back-to-back bursts must be contiguous.
    max_run = 0;
    push(12'h000, 32'h01234567);
    repeat (3) @(negedge clk);
    push(12'h050, 32'h89ABCDEF);
    wait_idle("b2b");
    chk("b2b_run", max_run, 16);

    // Fill the FIFO: pushes at E0..E4, one pop at E1 -> count 4 after E4.
    push(12'h200, 32'h11111111);
    push(12'h210, 32'h22222222);
    push(12'h220, 32'h33333333);
    push(12'h230, 32'h44444444);
    push(12'h240, 32'h55555555);
    chk("full_ready", req_ready, 0);
    push(12'h250, 32'h66666666);
    wait_idle("full");

    // Address wrap.
    push(12'hFFE, 32'h00000000);
    wait_idle("wrap");

    // Prefix-feature vector (8 or 10 characters depending on build).
    push(12'h100, 32'h0000000A);
    wait_idle("prefix");

    // Reset during the third character with two requests queued.
    push(12'h300, 32'hCAFEF00D);
    push(12'h310, 32'h12345678);
    push(12'h320, 32'h9ABCDEF0);
    nchars = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wen) nchars++;
      if (nchars == 3) break;
    end
    chk("mid_third_char", nchars, 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_wen", wen, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 1);
    repeat (30) @(negedge clk);
    chk("mid_quiet_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_hex_writer.md
Name: vga_hex_writer

Overview:
- Upstream feeder for the VGA text display write port (wen / w_addr / w_data into the character buffer).
- Accepts requests of the form "render this 32-bit value as hex text at this character address" via a valid/ready handshake and buffers them in a small FIFO.
- Drains each request as a burst of sequential single-character writes.
- Lets debug logic post register/PC values without owning character-by-character timing.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, minimum 2.
- ADDR_W, 12, character-buffer address width; matches the display w_addr.

Ports:
- clk  input  1  100 MHz system clock, same domain as the display write port
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  FIFO can accept; equals !full
- req_addr  input  ADDR_W  character address of the first (leftmost) character
- req_value  input  32  value to render
- wen  output  1  display write enable, one character per asserted cycle
- w_addr  output  ADDR_W  display character address
- w_data  output  8  ASCII character code
- busy  output  1  high while the FIFO is non-empty or a burst is in progress

Behaviour:
- Reset (asynchronous, immediate) sets:
  - FIFO empty; req_ready=1.
  - FSM to IDLE; wen=0, w_addr=0, w_data=0, busy=0.
- Reset mid-burst aborts the burst and discards all queued requests.
- FIFO push:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - Each entry stores {req_addr, req_value}.
  - Full = count==FIFO_DEPTH. A pop in the same cycle does not make room for a push in that cycle (req_ready depends only on count).
- Simultaneous push and pop when neither full nor empty: both happen; count is unchanged.
- FSM has two states, IDLE and EMIT, plus a character counter cnt (4 bits).
- IDLE:
  - If the FIFO is non-empty at an edge: pop the head, load value_sr and addr_r, set cnt=0, go to EMIT.
  - Otherwise wen=0.
- EMIT, each cycle:
  - wen=1, w_addr=addr_r, w_data=hex(value_sr[31:28]).
  - On the edge: value_sr shifts left by 4, addr_r increments, cnt increments.
- Last character (cnt==NCHAR-1), on that edge:
  - If the FIFO is non-empty: pop and reload immediately, staying in EMIT. Bursts run back-to-back with no bubble.
  - Otherwise go to IDLE.
- NCHAR = 8 (10 with the optional feature).
- Outputs are registered.
- Latency: accept at edge E0 → first wen high in the cycle after E1 → last character in the cycle after E(NCHAR).
- Hex mapping: nibble 0-9 → 8'h30+n; nibble 10-15 → 8'h41+(n-10), uppercase.
- Address arithmetic is modulo 2^ADDR_W: 4095+1 wraps to 0, with no clamping. Row boundaries are not interpreted.
- busy = (count!=0) || state==EMIT.
- Values are captured at push; later changes to req_value do not affect queued entries.

Optional Feature:
- Macro: VGA_HEX_PREFIX_EN.
- Defined:
  - Each burst emits "0x" first: 8'h30, then 8'h78, then 8 digits, so NCHAR=10.
  - The shift register does not shift during the two prefix cycles.
- Undefined: 8 digits only, NCHAR=8.

Decomposition:
- Package vga_pkg holds:
  - CHAR_ADDR_W=12, ASCII_0=8'h30, ASCII_A=8'h41, ASCII_X=8'h78.
  - State enum {IDLE, EMIT}.
  - Request struct {addr, value}.
- One sub-module, vga_req_fifo: synchronous FIFO with async reset, parameterised by DEPTH and WIDTH, exposing push / pop / full / empty / head.
- The nibble-to-ASCII function lives in vga_pkg.

Test Plan:
- After reset, single push addr=0x010, value=0xDEADBEEF → wen for 8 consecutive cycles starting 2 edges after accept; (addr,data) = (0x010,'D'=0x44), (0x011,'E'=0x45), … (0x017,'F'=0x46); then wen=0 and busy=0.
- Back-to-back: push value=0x01234567 @0x000, then 0x89ABCDEF @0x050 while the first burst runs → 16 contiguous wen cycles with no gap; 2nd burst starts at 0x050 with '8'=0x38.
- FIFO full: with DEPTH=4, stall the drain by pushing 5 requests within consecutive cycles → req_ready=0 when count reaches 4; 5th accepted only after a pop; all 5 bursts are emitted in order.
- Address wrap: push addr=0xFFE, value=0x00000000 → writes at 0xFFE, 0xFFF, 0x000 … 0x005, all with data 0x30.
- Reset mid-burst: assert rst at the 3rd character with 2 requests queued → wen drops in the same cycle, asynchronously; after release, busy=0, req_ready=1, no further writes.
- With VGA_HEX_PREFIX_EN: push addr=0x100, value=0x0000000A → 10 writes: '0'(0x30)@0x100, 'x'(0x78)@0x101, seven '0' @0x102-0x108, 'A'(0x41)@0x109.
